// File: rtl/instruction_mode_decoder_pkg.sv
// Shared definitions for the instruction mode decoder: mode encodings,
// instruction field positions and the one-hot mode vector type.
package instr_dec_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } mode_e;

    localparam int MODE_HI = 7;
    localparam int MODE_LO = 6;
    localparam int OPA_HI  = 5;
    localparam int OPA_LO  = 3;
    localparam int OPB_HI  = 2;
    localparam int OPB_LO  = 0;

    // Bit n set means mode n; all-zero is legal only straight out of reset.
    typedef logic [3:0] mode_onehot_t;

endpackage

// File: rtl/instruction_mode_decoder_if.sv
// Fetch-side request and execute-side decoded result of the decode stage.
interface instruction_mode_decoder_if;

    logic       instr_valid;
    logic [7:0] instruction;
    logic       out_valid;
    logic       mode0;
    logic       mode1;
    logic       mode2;
    logic       mode3;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [5:0] imm6;

    modport master (
        output instr_valid, instruction,
        input  out_valid, mode0, mode1, mode2, mode3, op_a, op_b, imm6
    );

    modport slave (
        input  instr_valid, instruction,
        output out_valid, mode0, mode1, mode2, mode3, op_a, op_b, imm6
    );

endinterface

// File: rtl/mode_onehot_dec.sv
// Combinational 2-to-4 decoder turning the instruction mode field into a
// one-hot flag vector.
module mode_onehot_dec
    import instr_dec_pkg::*;
(
    input  mode_e        mode,
    output mode_onehot_t onehot
);

    // Map each mode encoding to its single flag bit
    always_comb begin
        onehot = 4'b0000;
        case (mode)
            MODE0:   onehot = 4'b0001;
            MODE1:   onehot = 4'b0010;
            MODE2:   onehot = 4'b0100;
            MODE3:   onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    end

endmodule

// File: rtl/instruction_mode_decoder.sv
// Registered decode stage: captures a valid instruction word, reports its
// addressing mode as one-hot flags and splits the payload into operand fields.
module instruction_mode_decoder
    import instr_dec_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    instruction_mode_decoder_if.slave     bus
);

    mode_onehot_t mode_onehot_s;
    mode_onehot_t mode_r;
    logic         valid_r;
    logic [2:0]   op_a_r;
    logic [2:0]   op_b_r;
    logic [5:0]   imm6_r;

    mode_onehot_dec u_mode_dec (
        .mode   (mode_e'(bus.instruction[MODE_HI:MODE_LO])),
        .onehot (mode_onehot_s)
    );

    // Capture registers: reset clears, a valid word loads, otherwise fields hold
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            mode_r  <= 4'b0000;
            op_a_r  <= 3'b000;
            op_b_r  <= 3'b000;
            imm6_r  <= 6'b000000;
        end else if (bus.instr_valid) begin
            valid_r <= 1'b1;
            mode_r  <= mode_onehot_s;
            op_a_r  <= bus.instruction[OPA_HI:OPA_LO];
            op_b_r  <= bus.instruction[OPB_HI:OPB_LO];
            imm6_r  <= bus.instruction[OPA_HI:OPB_LO];
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = valid_r;
    assign bus.mode0     = mode_r[0];
    assign bus.mode1     = mode_r[1];
    assign bus.mode2     = mode_r[2];
    assign bus.mode3     = mode_r[3];
    assign bus.op_a      = op_a_r;
    assign bus.op_b      = op_b_r;
    assign bus.imm6      = imm6_r;

endmodule

// File: tb/tb_instruction_mode_decoder.sv
// Directed self-checking bench for the instruction mode decoder.
module tb_instruction_mode_decoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    instruction_mode_decoder_if bus ();

    instruction_mode_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle, let the edge pass, and leave the outputs ready to sample
    task automatic step(input logic r, input logic v, input logic [7:0] ins);
        @(negedge clk);
        rst             = r;
        bus.instr_valid = v;
        bus.instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [3:0] em,
                             input logic [2:0] ea, input logic [2:0] eb, input logic [5:0] ei);
        check_val({tag, ".valid"}, {15'd0, bus.out_valid}, {15'd0, ev});
        check_val({tag, ".mode"},  {12'd0, bus.mode3, bus.mode2, bus.mode1, bus.mode0}, {12'd0, em});
        check_val({tag, ".op_a"},  {13'd0, bus.op_a}, {13'd0, ea});
        check_val({tag, ".op_b"},  {13'd0, bus.op_b}, {13'd0, eb});
        check_val({tag, ".imm6"},  {10'd0, bus.imm6}, {10'd0, ei});
    endtask

    initial begin
        logic [7:0] sweep [4];
        logic [3:0] sweep_exp [4];
        logic [7:0] w;
        logic [3:0] m;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instruction = 8'hFF;

        // Reset dominates a valid all-ones word
        step(1'b1, 1'b1, 8'hFF);
        check_all("rst0", 1'b0, 4'b0000, 3'd0, 3'd0, 6'd0);
        step(1'b1, 1'b1, 8'hFF);
        check_all("rst1", 1'b0, 4'b0000, 3'd0, 3'd0, 6'd0);

        sweep[0] = 8'b00000000; sweep_exp[0] = 4'b0001;
        sweep[1] = 8'b01000000; sweep_exp[1] = 4'b0010;
        sweep[2] = 8'b10000000; sweep_exp[2] = 4'b0100;
        sweep[3] = 8'b11000000; sweep_exp[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, sweep[i]);
            check_all($sformatf("sweep%0d", i), 1'b1, sweep_exp[i], 3'd0, 3'd0, 6'd0);
        end

        step(1'b0, 1'b1, 8'b10_101_011);
        check_all("fields", 1'b1, 4'b0100, 3'b101, 3'b011, 6'b101011);

        step(1'b0, 1'b1, 8'h7F);
        check_all("accept7f", 1'b1, 4'b0010, 3'b111, 3'b111, 6'b111111);
        step(1'b0, 1'b0, 8'hC0);
        check_all("hold", 1'b0, 4'b0010, 3'b111, 3'b111, 6'b111111);
        step(1'b0, 1'b0, 8'h15);
        check_all("hold2", 1'b0, 4'b0010, 3'b111, 3'b111, 6'b111111);

        step(1'b1, 1'b1, 8'hC0);
        check_all("midrst", 1'b0, 4'b0000, 3'd0, 3'd0, 6'd0);
        step(1'b0, 1'b1, 8'h00);
        check_all("postrst", 1'b1, 4'b0001, 3'd0, 3'd0, 6'd0);

        // Every encoding, back to back
        for (int i = 0; i < 256; i++) begin
            w = 8'(i);
            case (w[7:6])
                2'b00:   m = 4'b0001;
                2'b01:   m = 4'b0010;
                2'b10:   m = 4'b0100;
                default: m = 4'b1000;
            endcase
            step(1'b0, 1'b1, w);
            check_all($sformatf("exh%0d", i), 1'b1, m, w[5:3], w[2:0], w[5:0]);
            check_val($sformatf("exh%0d.pop", i),
                      16'(bus.mode0) + 16'(bus.mode1) + 16'(bus.mode2) + 16'(bus.mode3), 16'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_mode_decoder.md
# instruction_mode_decoder

Registered decode stage for the 8-bit instruction word. Bits [7:6] select one of four addressing modes, reported as one-hot flags `mode0`..`mode3`. The low six bits are split into operand fields for the downstream execute stage. Sits between instruction fetch and operand select, with one cycle of latency.

## Interface

Parameters:
- None. The instruction width is fixed at 8 bits.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `instr_valid`  in  1  `instruction` carries a new word this cycle.
- `instruction`  in  8  Instruction word. [7:6] is the mode, [5:0] is the payload.
- `out_valid`  out  1  Decoded outputs were updated on the most recent edge.
- `mode0`  out  1  High when the captured instruction[7:6] = 2'b00.
- `mode1`  out  1  High when the captured instruction[7:6] = 2'b01.
- `mode2`  out  1  High when the captured instruction[7:6] = 2'b10.
- `mode3`  out  1  High when the captured instruction[7:6] = 2'b11.
- `op_a`  out  3  Captured instruction[5:3].
- `op_b`  out  3  Captured instruction[2:0].
- `imm6`  out  6  Captured instruction[5:0].

## Operation

- On an edge with `rst` = 1:
  - `out_valid` = 0.
  - `mode0`..`mode3` = 0. This is the only legal all-zero mode state.
  - `op_a`, `op_b` and `imm6` = 0.
- On an edge with `rst` = 0 and `instr_valid` = 1:
  - Exactly one of `mode0`..`mode3` is set, selected by instruction[7:6]; the other three clear.
  - `op_a`, `op_b` and `imm6` load from the instruction.
  - `out_valid` = 1.
- On an edge with `rst` = 0 and `instr_valid` = 0:
  - `out_valid` = 0.
  - Mode flags and fields hold their previous values.
- Bits [5:0] never affect the mode flags. Every one of the 256 encodings is legal; there is no illegal-instruction detection.
- `op_a`, `op_b` and `imm6` are always populated regardless of mode. Consumers choose which fields to use from the mode flag.
- Invariant after the first accepted instruction: `mode0`..`mode3` form exactly one-hot (popcount = 1) until the next reset.
- No X propagation: every output has a defined value from the first reset onward.

## Timing

- Latency is 1 cycle: an instruction presented with `instr_valid` at edge N appears on the outputs after edge N.
- Throughput is one instruction per cycle. Back-to-back valid words each update the outputs on consecutive edges.
- There is no backpressure: the block has no ready signal and always accepts input.
- `rst` takes priority over `instr_valid` on the same edge.
- Reset asserted mid-stream clears all outputs at that edge. The first valid word after `rst` drops is decoded normally.
- All outputs come directly from flops, so there is no combinational path from any input to any output.

## Structure

- Shared package `instr_dec_pkg` holds:
  - Mode encodings: `MODE0` = 2'b00, `MODE1` = 2'b01, `MODE2` = 2'b10, `MODE3` = 2'b11.
  - Field bit positions: `MODE_HI` = 7, `MODE_LO` = 6, `OPA_HI` = 5, `OPA_LO` = 3, `OPB_HI` = 2, `OPB_LO` = 0.
  - A 4-bit one-hot mode typedef.
- One combinational sub-module, `mode_onehot_dec`, maps a 2-bit mode to the 4-bit one-hot vector.
- The top level adds the input capture registers, the field split and the `out_valid` flop.

## Test plan

- Reset: drive `rst` = 1 for 2 cycles with `instr_valid` = 1 and `instruction` = 8'hFF -> all outputs 0 and `out_valid` = 0.
- Mode sweep: drive 8'b00000000, 8'b01000000, 8'b10000000 and 8'b11000000 back-to-back with `instr_valid` = 1. Each edge shows the one-hot value {`mode3`,`mode2`,`mode1`,`mode0`} as follows, with `out_valid` = 1 on each edge:
  - 8'b00000000 -> 0001
  - 8'b01000000 -> 0010
  - 8'b10000000 -> 0100
  - 8'b11000000 -> 1000
- Fields: drive 8'b10_101_011 -> `mode2` = 1, `op_a` = 3'b101, `op_b` = 3'b011, `imm6` = 6'b101011.
- Hold: after accepting 8'h7F, drive `instr_valid` = 0 with `instruction` = 8'hC0 -> `out_valid` = 0 and `mode1` stays 1 with fields unchanged.
- Reset mid-stream: `rst` = 1 on the same edge as valid 8'hC0 -> outputs 0. The next valid 8'h00 -> `mode0` = 1.
- Exhaustive: all 256 encodings with `instr_valid` = 1 -> mode flags match instruction[7:6] and are one-hot every cycle.
